// File: rtl/decode_pkg.sv
// Shared definitions for the ID stage and the downstream EX/MEM/WB stages:
// opcode constants, ALU operation encodings and the control bundle layouts.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // Bit positions inside the packed bundles, for stages that slice them
  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;
  localparam int M_BRANCH_BIT    = 2;
  localparam int M_MEMREAD_BIT   = 1;
  localparam int M_MEMWRITE_BIT  = 0;
  localparam int EX_REGDST_BIT   = 3;
  localparam int EX_ALUOP_HI_BIT = 2;
  localparam int EX_ALUOP_LO_BIT = 1;
  localparam int EX_ALUSRC_BIT   = 0;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
  } m_ctrl_t;

  typedef struct packed {
    logic   regdst;
    aluop_t aluop;
    logic   alusrc;
  } ex_ctrl_t;

endpackage

// File: rtl/decode_if.sv
// IF/ID inputs, MEM/WB write-back inputs and ID/EX outputs of the decode stage.
interface decode_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);

  logic [31:0]           if_id_instr;
  logic [DATA_W-1:0]     if_id_npc;
  logic                  mem_wb_reg_write;
  logic [REG_ADDR_W-1:0] mem_wb_write_reg;
  logic [DATA_W-1:0]     mem_wb_write_data;
  logic [1:0]            id_ex_wb;
  logic [2:0]            id_ex_m;
  logic [3:0]            id_ex_ex;
  logic [DATA_W-1:0]     id_ex_npc;
  logic [DATA_W-1:0]     id_ex_readdat1;
  logic [DATA_W-1:0]     id_ex_readdat2;
  logic [DATA_W-1:0]     id_ex_sign_ext;
  logic [4:0]            id_ex_instr_2016;
  logic [4:0]            id_ex_instr_1511;

  modport master (
    output if_id_instr, if_id_npc, mem_wb_reg_write, mem_wb_write_reg, mem_wb_write_data,
    input  id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_readdat1, id_ex_readdat2,
           id_ex_sign_ext, id_ex_instr_2016, id_ex_instr_1511
  );

  modport slave (
    input  if_id_instr, if_id_npc, mem_wb_reg_write, mem_wb_write_reg, mem_wb_write_data,
    output id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_readdat1, id_ex_readdat2,
           id_ex_sign_ext, id_ex_instr_2016, id_ex_instr_1511
  );

endinterface

// File: rtl/decode_regfile.sv
// 2-read / 1-write register file with register 0 hardwired to zero and a
// write-first bypass so a same-cycle write-back is visible to the decode.
module decode_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic              wr_active;

  // A write only takes effect outside reset and never to register 0
  assign wr_active = wr_en && (wr_addr != '0) && !rst;

  // Storage update: reset clears the whole array and drops any write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_active) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Combinational reads with write-first bypass and a forced-zero register 0
  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_data2 = regs[rd_addr2];
    if (rd_addr1 == '0) begin
      rd_data1 = '0;
    end else if (wr_active && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
    end
    if (rd_addr2 == '0) begin
      rd_data2 = '0;
    end else if (wr_active && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
    end
  end

endmodule

// File: rtl/decode.sv
// MIPS instruction-decode stage: control decode, register read, immediate
// sign extension and the ID/EX pipeline latch.
module decode
  import decode_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);

  logic [5:0]        opcode;
  logic [DATA_W-1:0] read1;
  logic [DATA_W-1:0] read2;
  logic [DATA_W-1:0] sign_ext;
  wb_ctrl_t          wb_c;
  m_ctrl_t           m_c;
  ex_ctrl_t          ex_c;

  assign opcode   = bus.if_id_instr[31:26];
  assign sign_ext = {{(DATA_W-16){bus.if_id_instr[15]}}, bus.if_id_instr[15:0]};

  decode_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (bus.if_id_instr[25:21]),
    .rd_addr2 (bus.if_id_instr[20:16]),
    .rd_data1 (read1),
    .rd_data2 (read2),
    .wr_en    (bus.mem_wb_reg_write),
    .wr_addr  (bus.mem_wb_write_reg),
    .wr_data  (bus.mem_wb_write_data)
  );

  // Opcode to control bundles; unknown opcodes become bubbles
  always_comb begin
    wb_c = '0;
    m_c  = '0;
    ex_c = '0;
    case (opcode)
      OP_RTYPE: begin
        wb_c.regwrite = 1'b1;
        ex_c.regdst   = 1'b1;
        ex_c.aluop    = ALUOP_FUNCT;
      end
      OP_LW: begin
        wb_c.regwrite = 1'b1;
        wb_c.memtoreg = 1'b1;
        m_c.memread   = 1'b1;
        ex_c.aluop    = ALUOP_ADD;
        ex_c.alusrc   = 1'b1;
      end
      OP_SW: begin
        m_c.memwrite  = 1'b1;
        ex_c.aluop    = ALUOP_ADD;
        ex_c.alusrc   = 1'b1;
      end
      OP_BEQ: begin
        m_c.branch    = 1'b1;
        ex_c.aluop    = ALUOP_SUB;
      end
      default: begin
      end
    endcase
  end

  // ID/EX latch: loads every non-reset cycle, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.id_ex_wb         <= '0;
      bus.id_ex_m          <= '0;
      bus.id_ex_ex         <= '0;
      bus.id_ex_npc        <= '0;
      bus.id_ex_readdat1   <= '0;
      bus.id_ex_readdat2   <= '0;
      bus.id_ex_sign_ext   <= '0;
      bus.id_ex_instr_2016 <= '0;
      bus.id_ex_instr_1511 <= '0;
    end else begin
      bus.id_ex_wb         <= wb_c;
      bus.id_ex_m          <= m_c;
      bus.id_ex_ex         <= ex_c;
      bus.id_ex_npc        <= bus.if_id_npc;
      bus.id_ex_readdat1   <= read1;
      bus.id_ex_readdat2   <= read2;
      bus.id_ex_sign_ext   <= sign_ext;
      bus.id_ex_instr_2016 <= bus.if_id_instr[20:16];
      bus.id_ex_instr_1511 <= bus.if_id_instr[15:11];
    end
  end

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for the decode stage.
module tb_decode;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  decode_if bus ();

  decode u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then step past the next rising edge
  task automatic applyStimulus(input logic r, input logic [31:0] instr, input logic [31:0] npc,
                               input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
    rst                   = r;
    bus.if_id_instr       = instr;
    bus.if_id_npc         = npc;
    bus.mem_wb_reg_write  = we;
    bus.mem_wb_write_reg  = wreg;
    bus.mem_wb_write_data = wdata;
    @(posedge clk);
    #1;
  endtask

  // One comparison point
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Check every ID/EX output is zero
  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wb"},   32'(bus.id_ex_wb), 32'h0);
    checkOutput({tag, "_m"},    32'(bus.id_ex_m), 32'h0);
    checkOutput({tag, "_ex"},   32'(bus.id_ex_ex), 32'h0);
    checkOutput({tag, "_npc"},  bus.id_ex_npc, 32'h0);
    checkOutput({tag, "_rd1"},  bus.id_ex_readdat1, 32'h0);
    checkOutput({tag, "_rd2"},  bus.id_ex_readdat2, 32'h0);
    checkOutput({tag, "_sext"}, bus.id_ex_sign_ext, 32'h0);
    checkOutput({tag, "_rt"},   32'(bus.id_ex_instr_2016), 32'h0);
    checkOutput({tag, "_rd"},   32'(bus.id_ex_instr_1511), 32'h0);
  endtask

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset for two cycles with a lw present; second cycle carries a write-back that must be dropped
    applyStimulus(1'b1, 32'h8C220004, 32'h00000100, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b1, 32'h8C220004, 32'h00000100, 1'b1, 5'd2, 32'h00000077);
    checkAllZero("reset");

    // Release reset: lw $2,4($1)
    applyStimulus(1'b0, 32'h8C220004, 32'h00000100, 1'b0, 5'd0, 32'h0);
    checkOutput("lw_m",    32'(bus.id_ex_m), 32'b010);
    checkOutput("lw_wb",   32'(bus.id_ex_wb), 32'b11);
    checkOutput("lw_ex",   32'(bus.id_ex_ex), 32'b0001);
    checkOutput("lw_sext", bus.id_ex_sign_ext, 32'h00000004);
    checkOutput("lw_rt",   32'(bus.id_ex_instr_2016), 32'd2);
    checkOutput("lw_npc",  bus.id_ex_npc, 32'h00000100);
    checkOutput("lw_rd1",  bus.id_ex_readdat1, 32'h0);
    checkOutput("lw_rd2_dropped_write", bus.id_ex_readdat2, 32'h0);

    // Write reg 5, then add $6,$5,$5
    applyStimulus(1'b0, 32'h00000000, 32'h00000104, 1'b1, 5'd5, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h00A53020, 32'h00000108, 1'b0, 5'd0, 32'h0);
    checkOutput("add_rd1", bus.id_ex_readdat1, 32'hDEADBEEF);
    checkOutput("add_rd2", bus.id_ex_readdat2, 32'hDEADBEEF);
    checkOutput("add_ex",  32'(bus.id_ex_ex), 32'b1100);
    checkOutput("add_wb",  32'(bus.id_ex_wb), 32'b10);
    checkOutput("add_m",   32'(bus.id_ex_m), 32'b000);
    checkOutput("add_rd",  32'(bus.id_ex_instr_1511), 32'd6);

    // Same-cycle write of reg 7 and sw reading rs=rt=7
    applyStimulus(1'b0, 32'hACE70000, 32'h0000010C, 1'b1, 5'd7, 32'h12345678);
    checkOutput("byp_rd1", bus.id_ex_readdat1, 32'h12345678);
    checkOutput("byp_rd2", bus.id_ex_readdat2, 32'h12345678);
    checkOutput("byp_m",   32'(bus.id_ex_m), 32'b001);
    checkOutput("byp_ex",  32'(bus.id_ex_ex), 32'b0001);
    checkOutput("byp_wb",  32'(bus.id_ex_wb), 32'b00);
    applyStimulus(1'b0, 32'hACE70000, 32'h0000010C, 1'b0, 5'd0, 32'h0);
    checkOutput("stored_r7", bus.id_ex_readdat1, 32'h12345678);

    // Write to reg 0 (with a same-cycle read of it), then beq $0,$0,-2
    applyStimulus(1'b0, 32'h1000FFFE, 32'h00000110, 1'b1, 5'd0, 32'hFFFFFFFF);
    checkOutput("r0_byp_rd1", bus.id_ex_readdat1, 32'h0);
    applyStimulus(1'b0, 32'h1000FFFE, 32'h00000114, 1'b0, 5'd0, 32'h0);
    checkOutput("beq_rd1",  bus.id_ex_readdat1, 32'h0);
    checkOutput("beq_rd2",  bus.id_ex_readdat2, 32'h0);
    checkOutput("beq_m",    32'(bus.id_ex_m), 32'b100);
    checkOutput("beq_ex",   32'(bus.id_ex_ex), 32'b0010);
    checkOutput("beq_sext", bus.id_ex_sign_ext, 32'hFFFFFFFE);

    // Unknown opcode becomes a bubble; npc passes through
    applyStimulus(1'b0, 32'hFC000000, 32'h00000011, 1'b0, 5'd0, 32'h0);
    checkOutput("unk_wb",  32'(bus.id_ex_wb), 32'h0);
    checkOutput("unk_m",   32'(bus.id_ex_m), 32'h0);
    checkOutput("unk_ex",  32'(bus.id_ex_ex), 32'h0);
    checkOutput("unk_npc", bus.id_ex_npc, 32'h00000011);

    // Load reg 3, confirm it reads back, reset, confirm it is cleared
    applyStimulus(1'b0, 32'h00000000, 32'h00000120, 1'b1, 5'd3, 32'h00000055);
    applyStimulus(1'b0, 32'h00631020, 32'h00000124, 1'b0, 5'd0, 32'h0);
    checkOutput("r3_before", bus.id_ex_readdat1, 32'h00000055);
    checkOutput("r3_before_rdf", 32'(bus.id_ex_instr_1511), 32'd2);
    applyStimulus(1'b1, 32'h00631020, 32'h00000128, 1'b0, 5'd0, 32'h0);
    checkAllZero("midrst");
    applyStimulus(1'b0, 32'h00631020, 32'h0000012C, 1'b0, 5'd0, 32'h0);
    checkOutput("r3_after_rd1", bus.id_ex_readdat1, 32'h0);
    checkOutput("r3_after_rd2", bus.id_ex_readdat2, 32'h0);
    checkOutput("r3_after_wb",  32'(bus.id_ex_wb), 32'b10);
    checkOutput("r5_after",     bus.id_ex_npc, 32'h0000012C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of the fetch stage.
- Consumes the IF/ID latch outputs (instruction, next PC) and decodes the opcode into WB/M/EX control bundles.
- Reads two operands from a 32x32 register file written back from MEM/WB, and sign-extends the immediate.
- Registers everything into the ID/EX latch for the execute stage.

Parameters:
- DATA_W, 32, datapath and register width
- REG_ADDR_W, 5, register-file address width (2**REG_ADDR_W registers)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_id_instr  in  32  instruction from IF/ID latch
- if_id_npc  in  32  next PC from IF/ID latch
- mem_wb_reg_write  in  1  write-back enable
- mem_wb_write_reg  in  5  write-back destination register
- mem_wb_write_data  in  32  write-back data
- id_ex_wb  out  2  {regwrite, memtoreg}
- id_ex_m  out  3  {branch, memread, memwrite}
- id_ex_ex  out  4  {regdst, aluop[1:0], alusrc}
- id_ex_npc  out  32  registered if_id_npc
- id_ex_readdat1  out  32  register rs contents
- id_ex_readdat2  out  32  register rt contents
- id_ex_sign_ext  out  32  sign-extended instr[15:0]
- id_ex_instr_2016  out  5  rt field
- id_ex_instr_1511  out  5  rd field

Behaviour:
- Reset:
  - Synchronous, sampled on the clk rising edge.
  - Clears all 32 registers and every ID/EX output to 0.
  - A write-back presented in the reset cycle is dropped.
  - The first valid ID/EX contents appear one cycle after rst deasserts.
- Latency:
  - Single stage. Instruction present on if_id_* in cycle N appears on id_ex_* after edge N+1.
  - No stall or flush input; the latch loads every non-reset cycle.
- Control decode on instr[31:26]:
  - 0x00 R-type: regdst=1, aluop=10, alusrc=0, branch=0, memread=0, memwrite=0, regwrite=1, memtoreg=0
  - 0x23 lw: regdst=0, aluop=00, alusrc=1, memread=1, regwrite=1, memtoreg=1, others 0
  - 0x2B sw: aluop=00, alusrc=1, memwrite=1, others 0; regdst and memtoreg are 0
  - 0x04 beq: aluop=01, branch=1, others 0
  - Any other opcode: all control bits 0, so the instruction behaves as a bubble.
- Register file:
  - Read addresses are rs=instr[25:21] and rt=instr[20:16]; reads are combinational.
  - Write happens at the rising edge when mem_wb_reg_write=1, mem_wb_write_reg!=0 and rst=0.
  - Register 0 always reads 0; writes to it are ignored.
  - Write-first bypass: if a write is enabled to a nonzero register equal to rs (or rt) in the same cycle, that read returns mem_wb_write_data. The ID/EX latch therefore captures the new value.
  - rs==rt with a bypass hit returns the bypassed value on both outputs.
- Sign extension: id_ex_sign_ext = {16{instr[15]}, instr[15:0]}.
- Field pass-through: instr[20:16] and instr[15:11] are latched unmodified. The regdst mux lives in execute.
- Simultaneous events:
  - A write-back and a decode of the same register in the same cycle resolve via the bypass.
  - rst wins over any write.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04
  - aluop encodings: 00 add, 01 sub, 10 funct
  - bit positions for the wb/m/ex bundles, reused by the execute, memory and write-back stages
- One natural sub-module: regfile, with 2 read ports, 1 write port, write-first bypass and reset clear.
- Control decode and the ID/EX latch stay in the top module; the control decode is a combinational always block.

Test Plan:
- Reset: hold rst=1 for 2 cycles with if_id_instr=0x8C220004 -> all id_ex_* are 0; registers are 0.
  - Release rst -> after 1 edge, id_ex_m=010, id_ex_wb=11, id_ex_ex=0001, id_ex_sign_ext=0x00000004, id_ex_instr_2016=2.
- Write then read: write reg 5 = 0xDEADBEEF, then decode R-type 0x00A53020 (add $6,$5,$5).
  - Required: readdat1=readdat2=0xDEADBEEF, id_ex_ex=1100, id_ex_wb=10, id_ex_instr_1511=6.
- Bypass: in the same cycle, write reg 7 = 0x12345678 and decode sw 0xACE70000 (rs=7, rt=7).
  - Required: after the edge, readdat1=readdat2=0x12345678 and id_ex_m=001.
- R0 protection: write reg 0 = 0xFFFFFFFF, then decode beq 0x1000FFFE.
  - Required: readdat1=readdat2=0, id_ex_m=100, id_ex_ex=0010, id_ex_sign_ext=0xFFFFFFFE.
- Unknown opcode and npc: if_id_instr=0xFC000000, if_id_npc=0x00000011.
  - Required: all control outputs 0 and id_ex_npc=0x00000011.
- Reset mid-stream: after loading reg 3 = 0x55, assert rst for 1 cycle.
  - Required: the next decode reading reg 3 returns 0, and id_ex_* read 0 during the reset cycle.
